// File: rtl/wb_lcd_reader.sv
// Wishbone slave that runs HD44780-style LCD read cycles (RW=1) and returns
// the busy-flag/address-counter or display RAM byte; optional busy-flag polling.
module wb_lcd_reader #(
    parameter int unsigned T_AS  = 3,
    parameter int unsigned T_EH  = 23,
    parameter int unsigned T_AH  = 2,
    parameter int unsigned T_CYC = 50,
    parameter int unsigned CW    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [7:0]  lcd_data_i,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_e,
    output logic        lcd_bus_req
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_EHIGH   = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_RECOVER = 3'd4;

    // Counter reload values; RECOVER covers what is left of the E rise-to-rise period.
    localparam logic [CW-1:0] AS_LD = CW'(T_AS - 1);
    localparam logic [CW-1:0] EH_LD = CW'(T_EH - 1);
    localparam logic [CW-1:0] AH_LD = CW'(T_AH - 1);
    localparam logic [CW-1:0] RC_LD = CW'(T_CYC - T_EH - T_AH - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rs_q, rs_d;
    logic          poll_q, poll_d;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          ack_q, ack_d;
    logic [31:0]   dat_o_q, dat_o_d;
    logic          lcd_rs_q, lcd_rs_d;
    logic          lcd_rw_q, lcd_rw_d;
    logic          lcd_e_q, lcd_e_d;
    logic          bus_req_q, bus_req_d;

    logic wb_req_c;
    logic ctrl_wr_c;
    logic busy_c;
    logic unused_c;

    assign wb_req_c  = wb_stb_i & wb_cyc_i & ~ack_q;
    assign ctrl_wr_c = wb_req_c & wb_we_i & (wb_adr_i[3:2] == 2'd0);
    assign busy_c    = (state_q != S_IDLE);
    assign unused_c  = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:4]};

    // Next-state logic: LCD read sequencer, register file and Wishbone response.
    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
        rs_d     = rs_q;
        poll_d   = poll_q;
        data_d   = data_q;
        done_d   = done_q;
        err_d    = err_q;
        ack_d    = 1'b0;
        dat_o_d  = dat_o_q;

        case (state_q)
            S_IDLE: begin
                if (ctrl_wr_c && wb_dat_i[0]) begin
                    rs_d    = wb_dat_i[1];
                    poll_d  = wb_dat_i[2];
                    done_d  = 1'b0;
                    cnt_d   = AS_LD;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = EH_LD;
                    state_d = S_EHIGH;
                end
            end
            S_EHIGH: begin
                if (cnt_q == '0) begin
                    data_d  = lcd_data_i;
                    cnt_d   = AH_LD;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    cnt_d   = RC_LD;
                    state_d = S_RECOVER;
                end
            end
            S_RECOVER: begin
                if (cnt_q == '0) begin
                    if (poll_q && !rs_q && data_q[7]) begin
                        cnt_d   = EH_LD;
                        state_d = S_EHIGH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wb_req_c) begin
            ack_d = 1'b1;
            case (wb_adr_i[3:2])
                2'd0:    dat_o_d = {29'b0, poll_q, rs_q, 1'b0};
                2'd1:    dat_o_d = {29'b0, err_q, done_q, busy_c};
                2'd2:    dat_o_d = {24'b0, data_q};
                default: dat_o_d = 32'b0;
            endcase
        end

        // A START refused because a read is in flight beats a simultaneous clear.
        if (ctrl_wr_c) begin
            if (wb_dat_i[3]) begin
                err_d = 1'b0;
            end
            if (wb_dat_i[0] && busy_c) begin
                err_d = 1'b1;
            end
        end

        bus_req_d = (state_d != S_IDLE);
        lcd_rw_d  = bus_req_d;
        lcd_rs_d  = bus_req_d & rs_d;
        lcd_e_d   = (state_d == S_EHIGH);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rs_q      <= 1'b0;
            poll_q    <= 1'b0;
            data_q    <= 8'h00;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ack_q     <= 1'b0;
            dat_o_q   <= 32'b0;
            lcd_rs_q  <= 1'b0;
            lcd_rw_q  <= 1'b0;
            lcd_e_q   <= 1'b0;
            bus_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rs_q      <= rs_d;
            poll_q    <= poll_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ack_q     <= ack_d;
            dat_o_q   <= dat_o_d;
            lcd_rs_q  <= lcd_rs_d;
            lcd_rw_q  <= lcd_rw_d;
            lcd_e_q   <= lcd_e_d;
            bus_req_q <= bus_req_d;
        end
    end

    assign wb_ack_o    = wb_stb_i & wb_cyc_i & ack_q;
    assign wb_dat_o    = dat_o_q;
    assign lcd_rs      = lcd_rs_q;
    assign lcd_rw      = lcd_rw_q;
    assign lcd_e       = lcd_e_q;
    assign lcd_bus_req = bus_req_q;

endmodule

// File: tb/tb_wb_lcd_reader.sv
// Directed bench for wb_lcd_reader: register access, read timing, polling, errors, reset, sampling edge.
module tb_wb_lcd_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_ack_o;
    logic        wb_we_i = 1'b0;
    logic [31:0] wb_adr_i = 32'h0;
    logic [3:0]  wb_sel_i = 4'hF;
    logic [31:0] wb_dat_i = 32'h0;
    logic [31:0] wb_dat_o;
    logic [7:0]  lcd_data_i = 8'h00;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_e;
    logic        lcd_bus_req;

    int total = 0;
    int bad = 0;

    wb_lcd_reader dut (
        .clk         (clk),
        .reset       (reset),
        .wb_stb_i    (wb_stb_i),
        .wb_cyc_i    (wb_cyc_i),
        .wb_ack_o    (wb_ack_o),
        .wb_we_i     (wb_we_i),
        .wb_adr_i    (wb_adr_i),
        .wb_sel_i    (wb_sel_i),
        .wb_dat_i    (wb_dat_i),
        .wb_dat_o    (wb_dat_o),
        .lcd_data_i  (lcd_data_i),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_e       (lcd_e),
        .lcd_bus_req (lcd_bus_req)
    );

    always #5 clk = ~clk;

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, output int lat);
        @(posedge clk);
        @(negedge clk);
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = a; wb_dat_i = d;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!wb_ack_o && lat < 8);
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output int lat);
        @(posedge clk);
        @(negedge clk);
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = a;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!wb_ack_o && lat < 8);
        d = wb_dat_o;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (lcd_bus_req && n < 400) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (n >= 400) begin bad++; $display("FAIL %s: transfer still busy after %0d cycles", name, n); end
    endtask

    task automatic wait_e_rise(input string name);
        int n = 0;
        while (!lcd_e && n < 200) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (n >= 200) begin bad++; $display("FAIL %s: E never rose within %0d cycles", name, n); end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int lat;
        #12;
        total++; if (lcd_e !== 1'b0) begin bad++; $display("FAIL rst_e: got %b want 0", lcd_e); end
        total++; if (lcd_bus_req !== 1'b0) begin bad++; $display("FAIL rst_busreq: got %b want 0", lcd_bus_req); end
        total++; if ({lcd_rw, lcd_rs} !== 2'b00) begin bad++; $display("FAIL rst_rwrs: got %b want 00", {lcd_rw, lcd_rs}); end
        total++; if (wb_dat_o !== 32'h0) begin bad++; $display("FAIL rst_dato: got %h want 0", wb_dat_o); end
        @(negedge clk); reset = 1'b1;
        wb_read(32'h4, d, lat);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_status: got %h want 0", d); end
        total++; if (lat !== 1) begin bad++; $display("FAIL rst_ack_lat_rd: got %0d want 1", lat); end
        wb_read(32'h8, d, lat);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 0", d); end
        wb_write(32'h4, 32'hFFFF_FFFF, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL rst_ack_lat_wr: got %0d want 1", lat); end
        @(posedge clk); #1;
        total++; if (wb_ack_o !== 1'b0) begin bad++; $display("FAIL ack_single: got %b want 0", wb_ack_o); end
        total++; if (lcd_bus_req !== 1'b0) begin bad++; $display("FAIL ignored_wr_busreq: got %b want 0", lcd_bus_req); end
        wb_read(32'h4, d, lat);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL ignored_wr_status: got %h want 0", d); end
        wb_read(32'hC, d, lat);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reg_0c: got %h want 0", d); end
    endtask

    task automatic test_single_read();
        logic [31:0] d;
        int lat;
        int n;
        lcd_data_i = 8'h41;
        wb_write(32'h0, 32'h3, lat);
        total++; if ({lcd_bus_req, lcd_rw, lcd_rs, lcd_e} !== 4'b1110) begin
            bad++; $display("FAIL single_setup_pins: got %b want 1110", {lcd_bus_req, lcd_rw, lcd_rs, lcd_e}); end
        n = 0;
        while (!lcd_e && n < 100) begin @(posedge clk); #1; n++; end
        total++; if (n !== 3) begin bad++; $display("FAIL single_tas: got %0d want 3", n); end
        n = 0;
        while (lcd_e && n < 100) begin @(posedge clk); #1; n++; end
        total++; if (n !== 23) begin bad++; $display("FAIL single_teh: got %0d want 23", n); end
        total++; if ({lcd_bus_req, lcd_rw, lcd_rs} !== 3'b111) begin
            bad++; $display("FAIL single_hold_pins: got %b want 111", {lcd_bus_req, lcd_rw, lcd_rs}); end
        wait_idle("single_idle");
        wb_read(32'h4, d, lat);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL single_status: got %h want 2", d); end
        wb_read(32'h8, d, lat);
        total++; if (d !== 32'h41) begin bad++; $display("FAIL single_data: got %h want 41", d); end
        wb_read(32'h0, d, lat);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL single_ctrl: got %h want 2", d); end
    endtask

    task automatic test_poll();
        logic [31:0] d;
        int lat;
        int t, rises, falls, last;
        logic pe, gap_bad;
        lcd_data_i = 8'h80;
        wb_write(32'h0, 32'h5, lat);
        t = 0; rises = 0; falls = 0; last = 0; pe = 1'b0; gap_bad = 1'b0;
        while (lcd_bus_req && t < 1000) begin
            @(posedge clk); #1; t++;
            if (lcd_e && !pe) begin
                rises++;
                if (rises > 1 && (t - last) != 50) gap_bad = 1'b1;
                last = t;
            end
            if (!lcd_e && pe) falls++;
            if (falls == 3) lcd_data_i = 8'h12;
            pe = lcd_e;
        end
        total++; if (rises !== 4) begin bad++; $display("FAIL poll_pulses: got %0d want 4", rises); end
        total++; if (gap_bad !== 1'b0) begin bad++; $display("FAIL poll_period: got irregular want 50 clk"); end
        wb_read(32'h8, d, lat);
        total++; if (d !== 32'h12) begin bad++; $display("FAIL poll_data: got %h want 12", d); end
        wb_read(32'h4, d, lat);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL poll_status: got %h want 2", d); end
        wb_read(32'h0, d, lat);
        total++; if (d !== 32'h4) begin bad++; $display("FAIL poll_ctrl: got %h want 4", d); end
        // POLL with RS=1 is a single read even though bit7 is set.
        lcd_data_i = 8'h80;
        wb_write(32'h0, 32'h7, lat);
        t = 0; rises = 0; pe = 1'b0;
        while (lcd_bus_req && t < 1000) begin
            @(posedge clk); #1; t++;
            if (lcd_e && !pe) rises++;
            pe = lcd_e;
        end
        total++; if (rises !== 1) begin bad++; $display("FAIL poll_rs1_pulses: got %0d want 1", rises); end
        wb_read(32'h8, d, lat);
        total++; if (d !== 32'h80) begin bad++; $display("FAIL poll_rs1_data: got %h want 80", d); end
    endtask

    task automatic test_error();
        logic [31:0] d;
        int lat;
        lcd_data_i = 8'h33;
        wb_write(32'h0, 32'h3, lat);
        wb_write(32'h0, 32'h1, lat);
        wb_read(32'h4, d, lat);
        total++; if (d !== 32'h5) begin bad++; $display("FAIL err_busy_status: got %h want 5", d); end
        wait_idle("err_idle1");
        wb_read(32'h8, d, lat);
        total++; if (d !== 32'h33) begin bad++; $display("FAIL err_data: got %h want 33", d); end
        wb_read(32'h4, d, lat);
        total++; if (d !== 32'h6) begin bad++; $display("FAIL err_done_status: got %h want 6", d); end
        wb_write(32'h0, 32'h8, lat);
        wb_read(32'h4, d, lat);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL err_clear: got %h want 2", d); end
        wb_write(32'h0, 32'h3, lat);
        wb_write(32'h0, 32'hD, lat);
        wb_read(32'h4, d, lat);
        total++; if (d !== 32'h5) begin bad++; $display("FAIL err_set_wins: got %h want 5", d); end
        wb_read(32'h0, d, lat);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL err_ctrl_kept: got %h want 2", d); end
        wait_idle("err_idle2");
        wb_write(32'h0, 32'h8, lat);
        wb_read(32'h4, d, lat);
        total++; if (d !== 32'h2) begin bad++; $display("FAIL err_clear2: got %h want 2", d); end
    endtask

    task automatic test_reset_midcycle();
        logic [31:0] d;
        int lat;
        lcd_data_i = 8'h77;
        wb_write(32'h0, 32'h3, lat);
        wait_e_rise("rstmid_rise");
        repeat (5) begin @(posedge clk); #1; end
        #2 reset = 1'b0;
        #1;
        total++; if (lcd_e !== 1'b0) begin bad++; $display("FAIL rstmid_e: got %b want 0", lcd_e); end
        total++; if (lcd_bus_req !== 1'b0) begin bad++; $display("FAIL rstmid_busreq: got %b want 0", lcd_bus_req); end
        @(negedge clk); reset = 1'b1;
        wb_read(32'h4, d, lat);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL rstmid_status: got %h want 0", d); end
        wb_read(32'h8, d, lat);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL rstmid_data: got %h want 0", d); end
    endtask

    task automatic test_sample_edge();
        logic [31:0] d;
        int lat;
        lcd_data_i = 8'hAA;
        wb_write(32'h0, 32'h3, lat);
        wait_e_rise("edge1_rise");
        repeat (22) begin @(posedge clk); #1; end
        total++; if (lcd_e !== 1'b1) begin bad++; $display("FAIL edge1_still_high: got %b want 1", lcd_e); end
        lcd_data_i = 8'h55;
        wait_idle("edge1_idle");
        wb_read(32'h8, d, lat);
        total++; if (d !== 32'h55) begin bad++; $display("FAIL edge_late_change: got %h want 55", d); end
        lcd_data_i = 8'hAA;
        wb_write(32'h0, 32'h3, lat);
        wait_e_rise("edge2_rise");
        repeat (23) begin @(posedge clk); #1; end
        total++; if (lcd_e !== 1'b0) begin bad++; $display("FAIL edge2_fell: got %b want 0", lcd_e); end
        lcd_data_i = 8'h55;
        wait_idle("edge2_idle");
        wb_read(32'h8, d, lat);
        total++; if (d !== 32'hAA) begin bad++; $display("FAIL edge_at_fall: got %h want aa", d); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_poll();
        test_error();
        test_reset_midcycle();
        test_sample_edge();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
